// File: rtl/sram_initiator.sv
// Two-port round-robin front end for a single-port SRAM with registered read data.
// Optional power-up zero scrub of the whole array is enabled by defining SRAM_INIT_SCRUB_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_SCRUB | writing zero to every address, one per cycle; both ports held off
// ST_RUN   | round-robin arbitration between ports A and B, one access per cycle
module sram_initiator #(
   parameter int AW = 8,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_cs,
   output logic          mem_write,
   output logic          mem_read,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out
);

   typedef enum logic {ST_SCRUB, ST_RUN} state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

`ifdef SRAM_INIT_SCRUB_EN
   localparam state_t RESET_STATE = ST_SCRUB;
   logic [AW-1:0] scrub_cnt;
`else
   localparam state_t RESET_STATE = ST_RUN;
`endif

   state_t        state;
   state_t        state_nxt;
   logic          prio;
   logic          prio_nxt;
   logic          cs_nxt;
   logic          write_nxt;
   logic          read_nxt;
   logic [AW-1:0] address_nxt;
   logic [DW-1:0] data_in_nxt;
   logic          tag_vld_nxt;
   logic          tag_port_nxt;
   logic [1:0]    tag_vld;
   logic [1:0]    tag_port;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      prio_nxt     = prio;
      a_ready      = 1'b0;
      b_ready      = 1'b0;
      cs_nxt       = 1'b0;
      write_nxt    = 1'b0;
      read_nxt     = 1'b0;
      address_nxt  = mem_address;
      data_in_nxt  = mem_data_in;
      tag_vld_nxt  = 1'b0;
      tag_port_nxt = PORT_A;
      case (state)
`ifdef SRAM_INIT_SCRUB_EN
         ST_SCRUB: begin
            cs_nxt      = 1'b1;
            write_nxt   = 1'b1;
            address_nxt = scrub_cnt;
            data_in_nxt = '0;
            if (scrub_cnt == '1) begin
               state_nxt = ST_RUN;
            end
         end
`endif
         ST_RUN: begin
            // Readies are held low while reset is asserted, even though the state is already RUN
            a_ready = rst_n && (!b_valid || prio == PORT_A);
            b_ready = rst_n && (!a_valid || prio == PORT_B);
            if (a_valid && a_ready) begin
               cs_nxt       = 1'b1;
               write_nxt    = a_we;
               read_nxt     = !a_we;
               address_nxt  = a_addr;
               data_in_nxt  = a_wdata;
               tag_vld_nxt  = !a_we;
               tag_port_nxt = PORT_A;
               prio_nxt     = PORT_B;
            end else if (b_valid && b_ready) begin
               cs_nxt       = 1'b1;
               write_nxt    = b_we;
               read_nxt     = !b_we;
               address_nxt  = b_addr;
               data_in_nxt  = b_wdata;
               tag_vld_nxt  = !b_we;
               tag_port_nxt = PORT_B;
               prio_nxt     = PORT_A;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

`ifdef SRAM_INIT_SCRUB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scrub_cnt <= '0;
      end else if (state == ST_SCRUB) begin
         scrub_cnt <= scrub_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_cs      <= 1'b0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         prio        <= PORT_A;
         tag_vld     <= '0;
         tag_port    <= '0;
         a_rvalid    <= 1'b0;
         b_rvalid    <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
      end else begin
         mem_cs      <= cs_nxt;
         mem_write   <= write_nxt;
         mem_read    <= read_nxt;
         mem_address <= address_nxt;
         mem_data_in <= data_in_nxt;
         prio        <= prio_nxt;
         // Stage 1 lines up with the SRAM output; capture happens one cycle after it
         tag_vld     <= {tag_vld[0], tag_vld_nxt};
         tag_port    <= {tag_port[0], tag_port_nxt};
         a_rvalid    <= tag_vld[1] && (tag_port[1] == PORT_A);
         b_rvalid    <= tag_vld[1] && (tag_port[1] == PORT_B);
         if (tag_vld[1] && tag_port[1] == PORT_A) begin
            a_rdata <= mem_data_out;
         end
         if (tag_vld[1] && tag_port[1] == PORT_B) begin
            b_rdata <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_sram_initiator.sv
// Directed self-checking bench for sram_initiator with a behavioural registered-read SRAM.
// Covers the scrub sequence too when SRAM_INIT_SCRUB_EN is defined.
`timescale 1ns/1ps
module tb_sram_initiator;
   localparam int AW = 8;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic          a_ready, b_ready;
   logic          a_we = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_cs, mem_write, mem_read;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out = '0;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] sram [0:(1<<AW)-1];

   sram_initiator #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_cs(mem_cs), .mem_write(mem_write), .mem_read(mem_read),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs && mem_write) sram[mem_address] <= mem_data_in;
      if (mem_cs && mem_read) mem_data_out <= sram[mem_address];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0; a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic wait_run();
`ifdef SRAM_INIT_SCRUB_EN
      int n = 0;
      #1;
      while (!a_ready && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_run: a_ready=%b after %0d cycles, required 1", a_ready, n);
      end
`endif
   endtask

   task automatic test_reset();
      a_valid = 1'b1; b_valid = 1'b1;
      step(); step();
      checks++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid, mem_cs, mem_write, mem_read} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {a_ready, b_ready, a_rvalid, b_rvalid, mem_cs, mem_write, mem_read});
      end
      checks++;
      if ({mem_address, mem_data_in, a_rdata, b_rdata} !== 20'h0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", {mem_address, mem_data_in, a_rdata, b_rdata});
      end
      idle();
      rst_n = 1'b1;
      wait_run();
   endtask

   task automatic test_write_read();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h3C; a_wdata = 4'hA;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b required 1", a_ready); end
      step();
      checks++;
      if ({mem_cs, mem_write, mem_read, mem_address, mem_data_in} !== {3'b110, 8'h3C, 4'hA}) begin
         errors++;
         $display("FAIL wr_issue: got %h required %h",
                  {mem_cs, mem_write, mem_read, mem_address, mem_data_in}, {3'b110, 8'h3C, 4'hA});
      end
      a_we = 1'b0;
      step();
      checks++;
      if ({mem_cs, mem_write, mem_read, mem_address} !== {3'b101, 8'h3C}) begin
         errors++;
         $display("FAIL rd_issue: got %h required %h", {mem_cs, mem_write, mem_read, mem_address}, {3'b101, 8'h3C});
      end
      idle();
      step();
      checks++;
      if ({mem_cs, a_rvalid} !== 2'b00) begin errors++; $display("FAIL rd_early: cs/rvalid=%b required 00", {mem_cs, a_rvalid}); end
      step();
      checks++;
      if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 4'hA}) begin
         errors++;
         $display("FAIL rd_return: rvalid a/b=%b%b rdata=%h required 10 A", a_rvalid, b_rvalid, a_rdata);
      end
      step();
      checks++;
      if ({a_rvalid, a_rdata} !== {1'b0, 4'hA}) begin
         errors++;
         $display("FAIL rd_hold: rvalid=%b rdata=%h required 0 A", a_rvalid, a_rdata);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_rdy;
      logic [1:0] exp_rv;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 4'h1;
      step();
      idle();
      b_valid = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 4'h2;
      step();
      idle();
      step();
      for (int i = 0; i < 9; i++) begin
         if (i < 6) begin
            a_valid = 1'b1; b_valid = 1'b1; a_addr = 8'h10; b_addr = 8'h20;
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({a_ready, b_ready} !== exp_rdy) begin
               errors++;
               $display("FAIL cont_ready[%0d]: got %b required %b", i, {a_ready, b_ready}, exp_rdy);
            end
         end else begin
            idle();
         end
         step();
         if (i >= 2 && i < 8) exp_rv = ((i - 2) % 2 == 0) ? 2'b10 : 2'b01;
         else exp_rv = 2'b00;
         checks++;
         if ({a_rvalid, b_rvalid} !== exp_rv) begin
            errors++;
            $display("FAIL cont_rvalid[%0d]: got %b required %b", i, {a_rvalid, b_rvalid}, exp_rv);
         end
         if (exp_rv == 2'b10) begin
            checks++;
            if (a_rdata !== 4'h1) begin errors++; $display("FAIL cont_adata[%0d]: got %h required 1", i, a_rdata); end
         end else if (exp_rv == 2'b01) begin
            checks++;
            if (b_rdata !== 4'h2) begin errors++; $display("FAIL cont_bdata[%0d]: got %h required 2", i, b_rdata); end
         end
      end
   endtask

   task automatic test_single_b();
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            b_valid = 1'b1; b_we = 1'b0; b_addr = (i % 2 == 0) ? 8'h10 : 8'h20;
            #1;
            checks++;
            if (b_ready !== 1'b1) begin errors++; $display("FAIL single_b_ready[%0d]: got %b required 1", i, b_ready); end
         end else begin
            idle();
         end
         step();
         checks++;
         if ({a_rvalid, b_rvalid} !== ((i >= 2 && i < 6) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL single_b_rvalid[%0d]: got %b", i, {a_rvalid, b_rvalid});
         end
         if (i >= 2 && i < 6) begin
            exp_d = ((i - 2) % 2 == 0) ? 4'h1 : 4'h2;
            checks++;
            if (b_rdata !== exp_d) begin errors++; $display("FAIL single_b_data[%0d]: got %h required %h", i, b_rdata, exp_d); end
         end
      end
   endtask

   task automatic test_raw();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h7F; a_wdata = 4'h5;
      step();
      idle();
      b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h7F;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin errors++; $display("FAIL raw_ready: got %b required 1", b_ready); end
      step();
      idle();
      step();
      checks++;
      if (b_rvalid !== 1'b0) begin errors++; $display("FAIL raw_early: b_rvalid=%b required 0", b_rvalid); end
      step();
      checks++;
      if ({b_rvalid, b_rdata} !== {1'b1, 4'h5}) begin
         errors++;
         $display("FAIL raw_data: rvalid=%b rdata=%h required 1 5", b_rvalid, b_rdata);
      end
   endtask

   task automatic test_reset_midflight();
      a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h3C;
      step();
      idle();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid, mem_cs, mem_write, mem_read, mem_address, mem_data_in, a_rdata, b_rdata}
          !== 27'h0) begin
         errors++;
         $display("FAIL midrst_zero: got %h required 0",
                  {a_ready, b_ready, a_rvalid, b_rvalid, mem_cs, mem_write, mem_read, mem_address, mem_data_in, a_rdata, b_rdata});
      end
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({a_rvalid, b_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_rvalid[%0d]: got %b required 00", i, {a_rvalid, b_rvalid});
         end
      end
      wait_run();
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_prio: ready a/b=%b required 10", {a_ready, b_ready});
      end
      idle();
      step();
   endtask

`ifdef SRAM_INIT_SCRUB_EN
   task automatic test_scrub();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'hFF; a_wdata = 4'hF;
      step();
      idle();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         a_valid = 1'b1; a_we = 1'b0; a_addr = 8'hFF; b_valid = 1'b1;
         #1;
         checks++;
         if ({a_ready, b_ready} !== 2'b00) begin
            errors++;
            $display("FAIL scrub_ready[%0d]: got %b required 00", k, {a_ready, b_ready});
         end
         step();
         checks++;
         if ({mem_cs, mem_write, mem_read, mem_address, mem_data_in} !== {3'b110, 8'(k - 1), 4'h0}) begin
            errors++;
            $display("FAIL scrub_issue[%0d]: got %h required %h", k,
                     {mem_cs, mem_write, mem_read, mem_address, mem_data_in}, {3'b110, 8'(k - 1), 4'h0});
         end
      end
      b_valid = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL scrub_first_ready: got %b required 1", a_ready); end
      step();
      idle();
      step(); step();
      checks++;
      if ({a_rvalid, a_rdata} !== {1'b1, 4'h0}) begin
         errors++;
         $display("FAIL scrub_readback: rvalid=%b rdata=%h required 1 0", a_rvalid, a_rdata);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
      test_reset();
      test_write_read();
      test_contention();
      test_single_b();
      test_raw();
      test_reset_midflight();
`ifdef SRAM_INIT_SCRUB_EN
      test_scrub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
